// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment digit scanner with a single-entry, frame-atomic update buffer.
module sevenseg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 27000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    blank_lz,
  output logic [3:0]              dig,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         disp;
  logic [DW-1:0]         shadow;
  logic                  pending;
  logic                  tick;
  logic                  wrap;
  logic                  xfer;
  logic [NUM_DIGITS-1:0] tail_zero;
  logic                  sel_zero;

  assign tick     = (cnt == CNT_LAST);
  assign wrap     = tick && (idx == IDX_LAST);
  assign in_ready = !pending && !rst;
  assign xfer     = in_valid && in_ready;

  // Slot prescaler, digit index and frame-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= wrap ? '0 : idx + IW'(1);
      end
      frame_start <= wrap;
    end
  end

  // Accept into the shadow buffer; copy to the display only at a frame wrap.
  // Accept and commit are exclusive: accept needs pending=0, commit needs pending=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= in_value;
      pending <= 1'b1;
    end else if (wrap && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  end

  // tail_zero[k] is set when every nibble from position k upward is zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    tail_zero = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      acc          = acc && (disp[4*k +: 4] == 4'd0);
      tail_zero[k] = acc;
    end
  end

  // Select the active nibble and drive the one-hot, active-low anode enables.
  always_comb begin
    dig      = 4'd0;
    sel_zero = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx == IW'(k)) begin
        dig      = disp[4*k +: 4];
        sel_zero = tail_zero[k];
      end
    end
    blank = blank_lz && (idx != '0) && sel_zero;
    an    = blank ? '1 : ~(NUM_DIGITS'(1) << idx);
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan (NUM_DIGITS=4, TICK_DIV=4): stimulus queues expected per-cycle outputs, monitor compares.
module tb_sevenseg_scan;

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [3:0] dig;
    logic       blank;
    logic       rdy;
    logic       fs;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic        blank_lz;
  logic [3:0]  dig;
  logic [3:0]  an;
  logic        blank;
  logic        frame_start;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   base  = 0;
  int   npass = 0;
  int   ntot  = 0;
  bit   done  = 1'b0;

  sevenseg_scan #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .blank_lz   (blank_lz),
    .dig        (dig),
    .an         (an),
    .blank      (blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare every queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && (sb[0].c < cyc || done)) begin
      e = sb.pop_front();
      ntot++;
      $display("FAIL %s c=%0d expectation never reached by monitor", e.tag, e.c - base);
    end
    while (sb.size() > 0 && sb[0].c == cyc) begin
      e = sb.pop_front();
      ntot++;
      if ({an, dig, blank, in_ready, frame_start} === {e.an, e.dig, e.blank, e.rdy, e.fs}) begin
        npass++;
      end else begin
        $display("FAIL %s c=%0d got an=%b dig=%h blank=%b rdy=%b fs=%b want an=%b dig=%h blank=%b rdy=%b fs=%b",
                 e.tag, e.c - base, an, dig, blank, in_ready, frame_start,
                 e.an, e.dig, e.blank, e.rdy, e.fs);
      end
    end
  end

  task automatic push_one(input int c, input logic [3:0] a, input logic [3:0] d,
                          input logic b, input logic r, input logic f, input string tag);
    exp_t x;
    x.c = base + c; x.an = a; x.dig = d; x.blank = b; x.rdy = r; x.fs = f; x.tag = tag;
    sb.push_back(x);
  endtask

  // Plain unblanked scan; org is the cycle where the scan restarted at position 0.
  task automatic push_scan(input int c0, input int c1, input int org,
                           input logic [15:0] d, input logic r, input string tag);
    for (int c = c0; c <= c1; c++) begin
      int r0;
      int id;
      r0 = c - org;
      id = (r0 / 4) % 4;
      push_one(c, ~(4'(1) << id), d[4*id +: 4], 1'b0, r, (r0 > 0) && (r0 % 16 == 0), tag);
    end
  endtask

  task automatic push_rep(input int c0, input int n, input logic [3:0] a, input logic [3:0] d,
                          input logic b, input logic r, input logic f0, input string tag);
    for (int i = 0; i < n; i++) push_one(c0 + i, a, d, b, r, f0 && (i == 0), tag);
  endtask

  task automatic wait_c(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_value = 16'h0; in_valid = 1'b0; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    #1;

    // Direct post-reset output checks.
    ntot++;
    if (in_ready === 1'b1) npass++;
    else $display("FAIL post_reset in_ready=%b want 1", in_ready);
    ntot++;
    if (an === 4'b1110) npass++;
    else $display("FAIL post_reset an=%b want 1110", an);
    ntot++;
    if (dig === 4'h0) npass++;
    else $display("FAIL post_reset dig=%h want 0", dig);
    ntot++;
    if (blank === 1'b0) npass++;
    else $display("FAIL post_reset blank=%b want 0", blank);
    ntot++;
    if (frame_start === 1'b0) npass++;
    else $display("FAIL post_reset frame_start=%b want 0", frame_start);

    // Free-running scan from reset, display all zeros.
    push_scan(0, 40, 0, 16'h0000, 1'b1, "free_run");

    // Single-cycle offer of 12AF mid-frame.
    wait_c(41);
    in_value = 16'h12AF; in_valid = 1'b1;
    push_scan(41, 41, 0, 16'h0000, 1'b1, "accept12AF");
    push_scan(42, 47, 0, 16'h0000, 1'b0, "pend12AF");
    push_scan(48, 63, 0, 16'h12AF, 1'b1, "show12AF");
    wait_c(42);
    in_valid = 1'b0;
    push_scan(64, 66, 0, 16'h12AF, 1'b1, "idle12AF");

    // 0001 accepted, then 0002 stalls until the commit of 0001.
    wait_c(66);
    in_value = 16'h0001; in_valid = 1'b1;
    push_scan(67, 79, 0, 16'h12AF, 1'b0, "stall2");
    push_scan(80, 80, 0, 16'h0001, 1'b1, "accept2");
    push_scan(81, 95, 0, 16'h0001, 1'b0, "pend2");
    push_scan(96, 111, 0, 16'h0002, 1'b1, "show2");
    wait_c(67);
    in_value = 16'h0002;
    wait_c(81);
    in_valid = 1'b0;

    // Load 0070, show unblanked, then blanked, then blanking released mid-slot.
    wait_c(112);
    in_value = 16'h0070; in_valid = 1'b1;
    push_scan(112, 112, 0, 16'h0002, 1'b1, "acc70");
    push_scan(113, 127, 0, 16'h0002, 1'b0, "pend70");
    push_scan(128, 143, 0, 16'h0070, 1'b1, "show70_nolz");
    wait_c(113);
    in_valid = 1'b0;
    push_rep(144, 4, 4'b1110, 4'h0, 1'b0, 1'b1, 1'b1, "lz70_p0");
    push_rep(148, 4, 4'b1101, 4'h7, 1'b0, 1'b1, 1'b0, "lz70_p1");
    push_rep(152, 2, 4'b1111, 4'h0, 1'b1, 1'b1, 1'b0, "lz70_p2");
    push_rep(154, 2, 4'b1011, 4'h0, 1'b0, 1'b1, 1'b0, "lzoff_p2");
    push_rep(156, 4, 4'b0111, 4'h0, 1'b0, 1'b1, 1'b0, "lzoff_p3");
    wait_c(144);
    blank_lz = 1'b1;
    wait_c(154);
    blank_lz = 1'b0;

    // All-zero display with blanking: only position 0 lit.
    wait_c(160);
    blank_lz = 1'b1; in_value = 16'h0000; in_valid = 1'b1;
    push_one(160, 4'b1110, 4'h0, 1'b0, 1'b1, 1'b1, "acc0");
    push_one(161, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0, "pend0");
    push_rep(176, 4, 4'b1110, 4'h0, 1'b0, 1'b1, 1'b1, "zero_p0");
    push_rep(180, 12, 4'b1111, 4'h0, 1'b1, 1'b1, 1'b0, "zero_blank");
    wait_c(161);
    in_valid = 1'b0;

    // Accept 5555, reset before the wrap; nothing offered during reset is taken.
    wait_c(194);
    in_value = 16'h5555; in_valid = 1'b1;
    push_one(194, 4'b1110, 4'h0, 1'b0, 1'b1, 1'b0, "acc5555");
    push_one(196, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0, "pend5555");
    wait_c(195);
    in_valid = 1'b0;
    wait_c(200);
    rst = 1'b1; blank_lz = 1'b0; in_value = 16'h9999; in_valid = 1'b1;
    push_one(200, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, "rst_rdy");
    #1;
    ntot++;
    if (in_ready === 1'b0) npass++;
    else $display("FAIL in_rst in_ready=%b want 0", in_ready);
    wait_c(201);
    rst = 1'b0; in_valid = 1'b0;
    push_scan(201, 241, 201, 16'h0000, 1'b1, "post_rst");

    wait_c(245);
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
